// File: rtl/pll_reset_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and lock-loss counter width.
// The PLL_RST state only exists when PLL_WATCHDOG_EN is defined.
package pll_reset_pkg;

    localparam int unsigned LLC_W = 8;

`ifdef PLL_WATCHDOG_EN
    typedef enum logic [2:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN,
        PLL_RST
    } state_e;
`else
    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        RUN
    } state_e;
`endif

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// Bundle between the reset sequencer and its surroundings: PLL lock in, stage resets and status out.
interface pll_reset_seq_if
    import pll_reset_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3
) ();

    logic                  locked;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  ready;
    logic [LLC_W-1:0]      lock_loss_cnt;
    logic                  pll_rst;

    modport master (
        input  locked,
        output rst_out,
        output ready,
        output lock_loss_cnt,
        output pll_rst
    );

    modport slave (
        output locked,
        input  rst_out,
        input  ready,
        input  lock_loss_cnt,
        input  pll_rst
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser, asynchronous active-high reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock qualifier and ordered reset release; re-asserts all stage resets on filtered lock loss.
// Optional PLL watchdog (pulses pll_rst when lock never arrives) enabled by macro PLL_WATCHDOG_EN.
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned HOLD_CYCLES    = 1024,
    parameter int unsigned STAGE_GAP      = 16,
    parameter int unsigned LOSS_FILTER    = 4,
    parameter int unsigned WD_TIMEOUT     = 65536,
    parameter int unsigned PLL_RST_CYCLES = 32
) (
    input  logic            clk_25MHz,
    input  logic            reset,
    pll_reset_seq_if.master pll_if
);

    localparam bit CFG_OK = (NUM_STAGES >= 1) && (HOLD_CYCLES >= 1) && (STAGE_GAP >= 1) &&
                            (LOSS_FILTER >= 1) && (WD_TIMEOUT >= 1) && (PLL_RST_CYCLES >= 1);

    if (!CFG_OK) begin : g_bad_cfg
        $error("pll_reset_seq: all counts must be >= 1");
    end

`ifdef PLL_WATCHDOG_EN
    localparam int unsigned CNT_MAX = max_u(max_u(HOLD_CYCLES, STAGE_GAP), PLL_RST_CYCLES);
    localparam int unsigned WW      = $clog2(WD_TIMEOUT + 1);
`else
    localparam int unsigned CNT_MAX = max_u(HOLD_CYCLES, STAGE_GAP);
`endif
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam int unsigned LW = $clog2(LOSS_FILTER + 1);

    logic locked_s;

    sync_2ff u_lock_sync (
        .clk_i (clk_25MHz),
        .rst_i (reset),
        .d_i   (pll_if.locked),
        .q_o   (locked_s)
    );

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [LW-1:0]         lcnt_q, lcnt_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  ready_q, ready_d;
    logic [LLC_W-1:0]      llc_q, llc_d;
    logic                  loss_hit;
`ifdef PLL_WATCHDOG_EN
    logic [WW-1:0]         wcnt_q, wcnt_d;
    logic                  pll_rst_q, pll_rst_d;
`endif

    always_ff @(posedge clk_25MHz or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            lcnt_q    <= '0;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            llc_q     <= '0;
`ifdef PLL_WATCHDOG_EN
            wcnt_q    <= '0;
            pll_rst_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lcnt_q    <= lcnt_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            llc_q     <= llc_d;
`ifdef PLL_WATCHDOG_EN
            wcnt_q    <= wcnt_d;
            pll_rst_q <= pll_rst_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lcnt_d    = '0;
        rst_out_d = rst_out_q;
        ready_d   = ready_q;
        llc_d     = llc_q;
        loss_hit  = 1'b0;
`ifdef PLL_WATCHDOG_EN
        wcnt_d    = '0;
        pll_rst_d = 1'b0;
`endif

        if ((state_q == RELEASE) || (state_q == RUN)) begin
            if (!locked_s) begin
                lcnt_d   = lcnt_q + LW'(1);
                loss_hit = (lcnt_q == LW'(LOSS_FILTER - 1));
            end
        end

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = HOLD;
                end
`ifdef PLL_WATCHDOG_EN
                else if (wcnt_q == WW'(WD_TIMEOUT - 1)) begin
                    state_d   = PLL_RST;
                    pll_rst_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
`endif
            end

            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d   = RELEASE;
                    cnt_d     = '0;
                    rst_out_d = rst_out_q << 1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Stages clear LSB-first by shifting zeros in; all-zero means the last stage is out.
            RELEASE: begin
                if (rst_out_q == '0) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(STAGE_GAP - 1)) begin
                    rst_out_d = rst_out_q << 1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RUN: begin
                cnt_d = '0;
            end

`ifdef PLL_WATCHDOG_EN
            PLL_RST: begin
                pll_rst_d = 1'b1;
                if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
                    state_d   = WAIT_LOCK;
                    pll_rst_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif

            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // Applied last so a loss landing on a release edge overrides the stage clear.
        if (loss_hit) begin
            state_d   = WAIT_LOCK;
            cnt_d     = '0;
            lcnt_d    = '0;
            rst_out_d = '1;
            ready_d   = 1'b0;
            if (llc_q != '1) begin
                llc_d = llc_q + LLC_W'(1);
            end
        end
    end

    assign pll_if.rst_out       = rst_out_q;
    assign pll_if.ready         = ready_q;
    assign pll_if.lock_loss_cnt = llc_q;
`ifdef PLL_WATCHDOG_EN
    assign pll_if.pll_rst       = pll_rst_q;
`else
    assign pll_if.pll_rst       = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with HOLD_CYCLES=8, STAGE_GAP=4, LOSS_FILTER=3, NUM_STAGES=3.
module tb_pll_reset_seq;

    localparam int unsigned NS = 3;

    logic clk_25MHz = 1'b0;
    logic reset     = 1'b1;
    int   checks    = 0;
    int   errors    = 0;

    always #5 clk_25MHz = ~clk_25MHz;

    pll_reset_seq_if #(.NUM_STAGES(NS)) pll_if ();

    pll_reset_seq #(
        .NUM_STAGES     (NS),
        .HOLD_CYCLES    (8),
        .STAGE_GAP      (4),
        .LOSS_FILTER    (3),
        .WD_TIMEOUT     (20),
        .PLL_RST_CYCLES (5)
    ) dut (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .pll_if    (pll_if)
    );

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    // Leaves reset deasserted 3 time units after an edge; the next edge is the first free-running one.
    task automatic do_reset();
        pll_if.locked = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pll_if.rst_out !== 3'b111) begin
            errors++;
            $display("FAIL reset_rst_out got %b want 111", pll_if.rst_out);
        end
        checks++;
        if (pll_if.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b want 0", pll_if.ready);
        end
        checks++;
        if (pll_if.lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_llc got %0d want 0", pll_if.lock_loss_cnt);
        end
        checks++;
        if (pll_if.pll_rst !== 1'b0) begin
            errors++;
            $display("FAIL reset_pll_rst got %b want 0", pll_if.pll_rst);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({pll_if.ready, pll_if.rst_out} !== 4'b0111) begin
                errors++;
                $display("FAIL unlocked_idle cyc %0d got %b want 0111", i, {pll_if.ready, pll_if.rst_out});
            end
        end
    endtask

    task automatic test_clean_lock();
        logic [2:0] exp_rst;
        logic       exp_rdy;
        do_reset();
        pll_if.locked = 1'b1;
        for (int e = 0; e <= 22; e++) begin
            tick();
            exp_rst = {e < 18, e < 14, e < 10};
            exp_rdy = (e >= 19);
            checks++;
            if ({pll_if.ready, pll_if.rst_out} !== {exp_rdy, exp_rst}) begin
                errors++;
                $display("FAIL clean_lock edge %0d got %b want %b", e, {pll_if.ready, pll_if.rst_out}, {exp_rdy, exp_rst});
            end
        end
        checks++;
        if (pll_if.lock_loss_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clean_lock_llc got %0d want 0", pll_if.lock_loss_cnt);
        end
    endtask

    task automatic test_hold_glitch();
        logic [2:0] exp_rst;
        do_reset();
        pll_if.locked = 1'b1;
        repeat (5) tick();
        pll_if.locked = 1'b0;
        tick();
        pll_if.locked = 1'b1;
        for (int e = 0; e <= 11; e++) begin
            tick();
            exp_rst = (e < 10) ? 3'b111 : 3'b110;
            checks++;
            if ({pll_if.ready, pll_if.rst_out} !== {1'b0, exp_rst}) begin
                errors++;
                $display("FAIL hold_glitch edge %0d got %b want %b", e, {pll_if.ready, pll_if.rst_out}, {1'b0, exp_rst});
            end
        end
    endtask

    task automatic test_run_glitch();
        logic [3:0] exp;
        do_reset();
        pll_if.locked = 1'b1;
        repeat (20) tick();
        checks++;
        if ({pll_if.ready, pll_if.rst_out} !== 4'b1000) begin
            errors++;
            $display("FAIL run_entry got %b want 1000", {pll_if.ready, pll_if.rst_out});
        end
        pll_if.locked = 1'b0;
        repeat (2) tick();
        pll_if.locked = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({pll_if.ready, pll_if.rst_out, pll_if.lock_loss_cnt} !== {4'b1000, 8'd0}) begin
                errors++;
                $display("FAIL run_short_glitch cyc %0d got %b/%0d want 1000/0", i, {pll_if.ready, pll_if.rst_out}, pll_if.lock_loss_cnt);
            end
        end
        pll_if.locked = 1'b0;
        for (int e = 1; e <= 23; e++) begin
            tick();
            if (e == 3) pll_if.locked = 1'b1;
            if (e < 5)       exp = 4'b1000;
            else if (e < 14) exp = 4'b0111;
            else             exp = {e >= 23, e < 22, e < 18, 1'b0};
            checks++;
            if ({pll_if.ready, pll_if.rst_out} !== exp) begin
                errors++;
                $display("FAIL run_loss edge %0d got %b want %b", e, {pll_if.ready, pll_if.rst_out}, exp);
            end
        end
        checks++;
        if (pll_if.lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL run_loss_llc got %0d want 1", pll_if.lock_loss_cnt);
        end
    endtask

    task automatic test_loss_at_release();
        logic [2:0] exp_rst;
        do_reset();
        pll_if.locked = 1'b1;
        repeat (10) tick();
        pll_if.locked = 1'b0;
        for (int e = 10; e <= 14; e++) begin
            tick();
            if (e == 12) pll_if.locked = 1'b1;
            exp_rst = (e < 14) ? 3'b110 : 3'b111;
            checks++;
            if (pll_if.rst_out !== exp_rst) begin
                errors++;
                $display("FAIL loss_vs_release edge %0d got %b want %b", e, pll_if.rst_out, exp_rst);
            end
        end
        checks++;
        if (pll_if.lock_loss_cnt !== 8'd1) begin
            errors++;
            $display("FAIL loss_vs_release_llc got %0d want 1", pll_if.lock_loss_cnt);
        end
    endtask

    task automatic test_saturation();
        int exp_cnt;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            pll_if.locked = 1'b1;
            repeat (11) tick();
            pll_if.locked = 1'b0;
            repeat (5) tick();
            exp_cnt = (i + 1 > 255) ? 255 : i + 1;
            if (i == 0 || i == 253 || i == 254 || i == 255) begin
                checks++;
                if (pll_if.lock_loss_cnt !== exp_cnt[7:0]) begin
                    errors++;
                    $display("FAIL llc_saturate event %0d got %0d want %0d", i + 1, pll_if.lock_loss_cnt, exp_cnt);
                end
            end
        end
        checks++;
        if ({pll_if.ready, pll_if.rst_out} !== 4'b0111) begin
            errors++;
            $display("FAIL llc_saturate_outputs got %b want 0111", {pll_if.ready, pll_if.rst_out});
        end
    endtask

    task automatic test_reset_mid_release();
        logic [2:0] exp_rst;
        logic       exp_rdy;
        do_reset();
        pll_if.locked = 1'b1;
        repeat (12) tick();
        checks++;
        if (pll_if.rst_out !== 3'b110) begin
            errors++;
            $display("FAIL mid_release_pre got %b want 110", pll_if.rst_out);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({pll_if.ready, pll_if.rst_out, pll_if.lock_loss_cnt, pll_if.pll_rst} !== {4'b0111, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got %b want 0111_00000000_0",
                     {pll_if.ready, pll_if.rst_out, pll_if.lock_loss_cnt, pll_if.pll_rst});
        end
        tick();
        tick();
        #2 reset = 1'b0;
        for (int e = 0; e <= 19; e++) begin
            tick();
            exp_rst = {e < 18, e < 14, e < 10};
            exp_rdy = (e >= 19);
            checks++;
            if ({pll_if.ready, pll_if.rst_out} !== {exp_rdy, exp_rst}) begin
                errors++;
                $display("FAIL restart edge %0d got %b want %b", e, {pll_if.ready, pll_if.rst_out}, {exp_rdy, exp_rst});
            end
        end
    endtask

    task automatic test_watchdog();
        logic exp;
        do_reset();
        for (int e = 1; e <= 60; e++) begin
            tick();
`ifdef PLL_WATCHDOG_EN
            exp = (e >= 20) && (((e - 20) % 25) < 5);
`else
            exp = 1'b0;
`endif
            checks++;
            if (pll_if.pll_rst !== exp) begin
                errors++;
                $display("FAIL watchdog edge %0d got %b want %b", e, pll_if.pll_rst, exp);
            end
        end
    endtask

    initial begin
        pll_if.locked = 1'b0;
        test_reset();
        test_clean_lock();
        test_hold_glitch();
        test_run_glitch();
        test_loss_at_release();
        test_saturation();
        test_reset_mid_release();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
